// File: rtl/qspi_rx_shifter_if.sv
// qspi_rx_shifter_if
//   Groups the control, serial-lane and result signals of the QSPI receive
//   deserialiser. The clock and reset are separate plain ports on the block.
//   master : frame control, sampling strobe, abort and lanes out; results in
//   slave  : the deserialiser side (control and lanes in, results out)
//   Signals: start_i, mode_i[1:0], lsb_first_i, len_i[CNT_W-1:0], sample_i,
//            abort_i, sdi_i[3:0] -> data_o[DATA_W-1:0], valid_o, busy_o,
//            err_o, bit_cnt_o[CNT_W-1:0]
interface qspi_rx_shifter_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
);
   logic              start_i;
   logic [1:0]        mode_i;
   logic              lsb_first_i;
   logic [CNT_W-1:0]  len_i;
   logic              sample_i;
   logic              abort_i;
   logic [3:0]        sdi_i;
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              busy_o;
   logic              err_o;
   logic [CNT_W-1:0]  bit_cnt_o;

   modport master (
      output start_i, mode_i, lsb_first_i, len_i, sample_i, abort_i, sdi_i,
      input  data_o, valid_o, busy_o, err_o, bit_cnt_o
   );

   modport slave (
      input  start_i, mode_i, lsb_first_i, len_i, sample_i, abort_i, sdi_i,
      output data_o, valid_o, busy_o, err_o, bit_cnt_o
   );
endinterface

// File: rtl/qspi_rx_shifter.sv
// qspi_rx_shifter
//   QSPI receive deserialiser with per-frame lane count (1/2/4), bit order and
//   frame length. Captures one lane group per sample strobe, reports a finished
//   frame with a one-cycle valid pulse and rejects bad length/mode programming.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : qspi_rx_shifter_if slave modport (control, lanes, results)
module qspi_rx_shifter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   qspi_rx_shifter_if.slave      bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_e;

   state_e            state_q;
   logic [1:0]        mode_q;
   logic              lsb_q;
   logic [CNT_W-1:0]  len_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              busy_q;
   logic              err_q;

   logic [2:0]        lane_cnt;
   logic [3:0]        lanes;
   logic [DATA_W-1:0] shreg_d;
   logic [CNT_W-1:0]  bit_cnt_d;
   logic              len_mult_ok;
   logic              start_bad;

   // Lane group for the latched mode; single mode uses sdi_i[1] as its lane.
   always_comb begin
      lane_cnt = 3'd4;
      lanes    = bus.sdi_i;
      case (mode_q)
         2'b00: begin
            lane_cnt = 3'd1;
            lanes    = {3'b000, bus.sdi_i[1]};
         end
         2'b01: begin
            lane_cnt = 3'd2;
            lanes    = {2'b00, bus.sdi_i[1:0]};
         end
         default: begin
            lane_cnt = 3'd4;
            lanes    = bus.sdi_i;
         end
      endcase
   end

   // The shift register is cleared at frame start, so LSB-first can OR the
   // group in at bit_cnt and MSB-first stays right-justified automatically.
   always_comb begin
      if (lsb_q) begin
         shreg_d = shreg_q | (DATA_W'(lanes) << bit_cnt_q);
      end else begin
         shreg_d = (shreg_q << lane_cnt) | DATA_W'(lanes);
      end
      bit_cnt_d = bit_cnt_q + CNT_W'(lane_cnt);
   end

   always_comb begin
      case (bus.mode_i)
         2'b00:   len_mult_ok = 1'b1;
         2'b01:   len_mult_ok = ~bus.len_i[0];
         2'b10:   len_mult_ok = (bus.len_i[1:0] == 2'b00);
         default: len_mult_ok = 1'b0;
      endcase
      start_bad = (bus.mode_i == 2'b11) || (bus.len_i == '0) ||
                  (bus.len_i > CNT_W'(DATA_W)) || !len_mult_ok;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         mode_q    <= '0;
         lsb_q     <= 1'b0;
         len_q     <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start_i) begin
                  mode_q <= bus.mode_i;
                  lsb_q  <= bus.lsb_first_i;
                  len_q  <= bus.len_i;
                  if (start_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     shreg_q   <= '0;
                     bit_cnt_q <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               if (bus.abort_i) begin
                  shreg_q   <= '0;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_IDLE;
               end else if (bus.sample_i) begin
                  shreg_q   <= shreg_d;
                  bit_cnt_q <= bit_cnt_d;
                  if (bit_cnt_d == len_q) begin
                     // Output registers load on entry to DONE so data_o and
                     // valid_o are visible throughout the DONE cycle.
                     data_q  <= shreg_d;
                     valid_q <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               bit_cnt_q <= '0;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.data_o    = data_q;
   assign bus.valid_o   = valid_q;
   assign bus.busy_o    = busy_q;
   assign bus.err_o     = err_q;
   assign bus.bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_qspi_rx_shifter.sv
// tb_qspi_rx_shifter
//   Self-checking bench for qspi_rx_shifter. Expected words are queued when a
//   frame is driven and compared when valid_o is seen.
module tb_qspi_rx_shifter;
   localparam int DW = 32;
   localparam int CW = $clog2(DW) + 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   qspi_rx_shifter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

   qspi_rx_shifter #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [1:0] m, input logic lsb, input logic [CW-1:0] len);
      bus.start_i     = 1'b1;
      bus.mode_i      = m;
      bus.lsb_first_i = lsb;
      bus.len_i       = len;
      tick();
      bus.start_i     = 1'b0;
      // scramble the programming inputs: latched values must be used
      bus.mode_i      = 2'($urandom);
      bus.lsb_first_i = 1'($urandom);
      bus.len_i       = CW'($urandom);
   endtask

   task automatic send(input logic [3:0] g);
      bus.sample_i = 1'b1;
      bus.sdi_i    = g;
      tick();
      bus.sample_i = 1'b0;
      bus.sdi_i    = 4'($urandom);
   endtask

   // scoreboard: every valid_o pulse must match the oldest expected word
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.valid_o === 1'b1) begin
         if (exp_q.size() == 0) check("valid_unexpected", 64'(bus.valid_o), 64'd0);
         else                   check("data_o", 64'(bus.data_o), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  bits;
      logic [3:0]  g[8];
      logic [DW-1:0] mdl;

      rst_n           = 1'b0;
      bus.start_i     = 1'b0;
      bus.mode_i      = 2'b00;
      bus.lsb_first_i = 1'b0;
      bus.len_i       = '0;
      bus.sample_i    = 1'b0;
      bus.abort_i     = 1'b0;
      bus.sdi_i       = 4'h0;
      #12;
      check("rst_data",  64'(bus.data_o),    64'd0);
      check("rst_valid", 64'(bus.valid_o),   64'd0);
      check("rst_busy",  64'(bus.busy_o),    64'd0);
      check("rst_err",   64'(bus.err_o),     64'd0);
      check("rst_cnt",   64'(bus.bit_cnt_o), 64'd0);
      rst_n = 1'b1;
      tick();

      // 1: quad MSB-first, len 32
      start_frame(2'b10, 1'b0, CW'(32));
      check("t1_busy", 64'(bus.busy_o), 64'd1);
      check("t1_cnt0", 64'(bus.bit_cnt_o), 64'd0);
      exp_q.push_back(32'h12345678);
      for (int k = 1; k <= 8; k++) begin
         send(4'(k));
         check("t1_cnt", 64'(bus.bit_cnt_o), 64'(4 * k));
         if (k < 8) check("t1_novalid", 64'(bus.valid_o), 64'd0);
      end
      check("t1_valid", 64'(bus.valid_o), 64'd1);
      check("t1_busy_done", 64'(bus.busy_o), 64'd1);
      // start during DONE is ignored
      bus.start_i = 1'b1; bus.mode_i = 2'b10; bus.len_i = CW'(32);
      tick();
      bus.start_i = 1'b0;
      check("t1_valid_fall", 64'(bus.valid_o), 64'd0);
      check("t1_busy_fall", 64'(bus.busy_o), 64'd0);
      check("t1_cnt_idle", 64'(bus.bit_cnt_o), 64'd0);
      check("t1_hold", 64'(bus.data_o), 64'h12345678);

      // 2: quad LSB-first, len 32
      start_frame(2'b10, 1'b1, CW'(32));
      exp_q.push_back(32'h87654321);
      for (int k = 1; k <= 8; k++) begin
         send(4'(k));
         check("t2_cnt", 64'(bus.bit_cnt_o), 64'(4 * k));
      end
      check("t2_valid", 64'(bus.valid_o), 64'd1);
      tick();

      // 3: single MSB-first, len 8, strobe every other cycle
      start_frame(2'b00, 1'b0, CW'(8));
      exp_q.push_back(32'h000000A5);
      bits = 8'b1010_0101;
      for (int k = 0; k < 8; k++) begin
         send({2'b00, bits[7-k], 1'b0});
         if (k < 7) begin
            tick();
            check("t3_gap_cnt", 64'(bus.bit_cnt_o), 64'(k + 1));
            check("t3_novalid", 64'(bus.valid_o), 64'd0);
         end
      end
      check("t3_valid", 64'(bus.valid_o), 64'd1);
      tick();

      // 4: dual LSB-first, len 6
      start_frame(2'b01, 1'b1, CW'(6));
      exp_q.push_back(32'h0000002D);
      send(4'b0001);
      send(4'b0011);
      send(4'b0010);
      check("t4_valid", 64'(bus.valid_o), 64'd1);
      tick();

      // 5: rejected programming (bad multiple, zero, reserved mode, too long)
      for (int r = 0; r < 4; r++) begin
         case (r)
            0:       start_frame(2'b01, 1'b0, CW'(7));
            1:       start_frame(2'b10, 1'b0, CW'(0));
            2:       start_frame(2'b11, 1'b0, CW'(8));
            default: start_frame(2'b10, 1'b0, CW'(36));
         endcase
         check("t5_err", 64'(bus.err_o), 64'd1);
         check("t5_busy", 64'(bus.busy_o), 64'd0);
         tick();
         check("t5_err_fall", 64'(bus.err_o), 64'd0);
      end
      check("t5_data", 64'(bus.data_o), 64'h2D);

      // 6: abort with 3rd sample, then an immediate good frame
      start_frame(2'b10, 1'b0, CW'(32));
      send(4'h1);
      send(4'h2);
      bus.abort_i = 1'b1;
      send(4'h3);
      bus.abort_i = 1'b0;
      check("t6_busy", 64'(bus.busy_o), 64'd0);
      check("t6_cnt", 64'(bus.bit_cnt_o), 64'd0);
      check("t6_novalid", 64'(bus.valid_o), 64'd0);
      check("t6_data", 64'(bus.data_o), 64'h2D);
      start_frame(2'b10, 1'b0, CW'(32));
      mdl = '0;
      for (int k = 0; k < 8; k++) begin
         g[k] = 4'($urandom);
         mdl  = (mdl << 4) | DW'(g[k]);
      end
      exp_q.push_back(mdl);
      for (int k = 0; k < 8; k++) send(g[k]);
      check("t6_valid", 64'(bus.valid_o), 64'd1);
      tick();

      // async reset mid-frame
      start_frame(2'b10, 1'b0, CW'(32));
      send(4'h5);
      send(4'h6);
      check("t7_cnt", 64'(bus.bit_cnt_o), 64'd8);
      #2 rst_n = 1'b0;
      #1;
      check("t7_data", 64'(bus.data_o), 64'd0);
      check("t7_busy", 64'(bus.busy_o), 64'd0);
      check("t7_cnt0", 64'(bus.bit_cnt_o), 64'd0);
      check("t7_valid", 64'(bus.valid_o), 64'd0);
      check("t7_err", 64'(bus.err_o), 64'd0);
      #3 rst_n = 1'b1;
      tick();
      check("t7_idle", 64'(bus.busy_o), 64'd0);

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
